circular_q_param: RTL
=====================

# circular_q_param

Parametrised successor to the core's single-width circular queue: a synchronous FIFO with configurable data width and depth, an occupancy count, an almost-full threshold, synchronous flush, and correct simultaneous enqueue/dequeue when full. It buffers entries between pipeline stages in the out-of-order core, for example instruction fetch to decode and reservation-station feeds. Dequeued data is registered and qualified by a one-cycle `ready` pulse.

## Interface
- `WIDTH`, 32: data width in bits, ≥1.
- `DEPTH`, 8: number of entries, ≥2. Need not be a power of two.
- `ALMOST_FULL`, DEPTH-1: `almost_full` asserts when count ≥ this value. Range 1..DEPTH.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `enq` in 1: enqueue request, `in` is sampled with it.
- `deq` in 1: dequeue request.
- `flush` in 1: synchronous clear of all entries.
- `in` in WIDTH: enqueue data.
- `out` out WIDTH: last dequeued entry, registered.
- `ready` out 1: `out` was updated by the previous edge.
- `empty` out 1: count == 0.
- `full` out 1: count == DEPTH.
- `almost_full` out 1: count ≥ ALMOST_FULL.
- `count` out $clog2(DEPTH+1): current occupancy.

## Operation
- State: storage array[DEPTH], head and tail pointers of $clog2(DEPTH) bits, and a count register. Storage is not reset.
- Pointers wrap from DEPTH-1 to 0 by explicit compare, not by natural overflow.
- Accepted enq (enq_ok) = `enq` && (!full || deq_ok). On enq_ok: mem[tail] <= in, tail advances.
- Accepted deq (deq_ok) = `deq` && !empty. On deq_ok: out <= mem[head], head advances, ready <= 1. Otherwise ready <= 0 and `out` holds its value.
- Count update: +1 on enq_ok only, -1 on deq_ok only, unchanged when both or neither.
- Full with enq and deq in the same cycle: both accepted, count stays DEPTH, and the oldest entry goes to `out`.
- Empty with enq and deq in the same cycle: enq accepted, deq ignored unless CQ_BYPASS_EN is defined (see Configuration).
- Enq while full with no deq: dropped silently, no state change.
- Deq while empty: ignored, ready <= 0.
- `flush` has priority over enq and deq. At the next edge: head = tail = count = 0 and ready <= 0. `out` holds its value. enq and deq in the flush cycle are discarded.
- `rst` at any time, including mid-burst: immediately sets head = tail = count = 0, out = 0, ready = 0. It overrides `flush`.

## Timing
- Reset values: out = 0, ready = 0, empty = 1, full = 0, almost_full = 0, count = 0.
- `empty`, `full`, `almost_full` and `count` decode from the count register only. They have no combinational path from inputs.
- Enqueue latency: entry written at edge N. `empty` falls after edge N. The earliest deq is sampled at edge N+1, with `out` valid and `ready` = 1 during cycle N+1.
- Dequeue latency: deq sampled at edge N gives `out` and `ready` in cycle N. `ready` is high for exactly one cycle per accepted deq.
- Back-to-back deq produces one entry per cycle with `ready` held high.
- Sustained simultaneous enq and deq gives a throughput of 1 entry per cycle at any occupancy from 1 to DEPTH.

## Configuration
- Macro `CQ_BYPASS_EN`.
- Defined: when empty and both enq and deq are asserted, `in` bypasses storage. `out` <= in and ready <= 1 at the next edge, while count, head and tail stay unchanged. This adds a combinational path from `in` to the `out` register D-input only.
- Undefined: behaviour on empty with enq and deq is as in Operation: only the enqueue happens, count becomes 1 and ready <= 0.

## Test plan
(WIDTH = 32, DEPTH = 8, ALMOST_FULL = 7)
- Reset, then enq 1..8 on consecutive cycles -> count = 8, full = 1, almost_full asserted after the 7th edge. A 9th enq of 9 is dropped with count still 8.
- Dequeue 5 -> out = 1,2,3,4,5 in consecutive cycles with ready = 1. Then enq 9..13 to wrap tail past 7 -> 13 entries pushed total, count = 8. Dequeue 8 -> out = 6..13 in order, then empty = 1.
- Full queue with enq and deq for 10 cycles on in = 1..10 -> count stays 8, and out is the 8 resident entries followed by 1, 2 in order.
- Empty queue with enq and deq for one cycle, in = 0xDEAD: without the macro -> count = 1, ready = 0. With `CQ_BYPASS_EN` -> out = 0xDEAD, ready = 1, count = 0.
- Count 5 with flush, enq and deq together -> next cycle count = 0, empty = 1, ready = 0, `out` unchanged. The next enq 0x42 followed by deq yields out = 0x42.
- Assert `rst` asynchronously mid-burst at count = 6 -> outputs immediately take reset values without a clock edge. After release, enq 7 then deq gives out = 7.

Source files
------------

// File: rtl/circular_q_param.sv
// Parametrised synchronous circular FIFO with occupancy count, almost-full flag,
// flush and registered dequeue output. Optional macro CQ_BYPASS_EN: empty enq+deq passes in straight to out.
module circular_q_param #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 8,
    parameter int ALMOST_FULL = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq,
    input  logic                       deq,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           in,
    output logic [WIDTH-1:0]           out,
    output logic                       ready,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head, tail;
    logic [CW-1:0]    cnt;
    logic             enq_ok, deq_ok, byp;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty       = (cnt == '0);
    assign full        = (cnt == CW'(DEPTH));
    assign almost_full = (cnt >= CW'(ALMOST_FULL));
    assign count       = cnt;

    assign deq_ok = deq && !empty;
    // A dequeue in the same cycle frees the slot, so a full queue still accepts.
    assign enq_ok = enq && (!full || deq_ok);

`ifdef CQ_BYPASS_EN
    assign byp = enq && deq && empty;
`else
    assign byp = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
            out   <= '0;
            ready <= 1'b0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            ready <= 1'b0;
            if (byp) begin
                out   <= in;
                ready <= 1'b1;
            end else begin
                if (deq_ok) begin
                    out   <= mem[head];
                    head  <= nxt(head);
                    ready <= 1'b1;
                end
                if (enq_ok)
                    tail <= nxt(tail);
                case ({enq_ok, deq_ok})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (enq_ok && !flush && !byp)
            mem[tail] <= in;
    end
endmodule
